// File: rtl/mips_debug_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_debug_pkg
// Purpose  : Shared types and constants for the MIPS run-control/debug unit.
// Revision : 1.0 - initial release
// ============================================================================
package mips_debug_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } dbg_state_t;

    localparam int CYCLE_W = 32;
    localparam logic [CYCLE_W-1:0] c_cycle_max = '1;

endpackage
`default_nettype wire

// File: rtl/mips_debug_ctrl_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : debug_edge_detect
// Purpose  : Rising-edge detector; history resets high so a held level is not an edge.
// Revision : 1.0 - initial release
// ============================================================================
module debug_edge_detect #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] btn,
    output logic [W-1:0] rise
);

    logic [W-1:0] r_btn_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_btn_q <= '1;
        end else begin
            r_btn_q <= btn;
        end
    end

    assign rise = btn & ~r_btn_q;

endmodule
`default_nettype wire

// File: rtl/mips_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_debug_ctrl
// Purpose  : Run/halt/step/breakpoint control of the MIPS core plus a
//            registered N-source debug readout with a valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module mips_debug_ctrl
    import mips_debug_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int N_SRC  = 4,
    parameter int SEL_W  = $clog2(N_SRC)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run_btn,
    input  logic                    halt_btn,
    input  logic                    step_btn,
    input  logic                    bp_en,
    input  logic [PC_W-1:0]         bp_addr,
    input  logic [PC_W-1:0]         core_pc,
    output logic                    core_enable,
    output logic                    halted,
    output logic [CYCLE_W-1:0]      cycle_count,
    input  logic [ADDR_W-1:0]       derreference,
    input  logic [SEL_W-1:0]        select,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic [DATA_W-1:0]       word,
    output logic                    word_valid
);

    logic [2:0]         w_rise;
    logic               w_halt_e;
    logic               w_run_e;
    logic               w_step_e;
    dbg_state_t         r_state;
    dbg_state_t         w_next;
    logic               r_resume;
    logic               w_bp_hit;
    logic [CYCLE_W-1:0] r_cycle_cnt;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [SEL_W-1:0]   r_sel_q;
    logic [31:0]        w_sel_ext;
    logic [DATA_W-1:0]  w_word_next;
    logic [DATA_W-1:0]  r_word;
    logic [1:0]         r_vld_sr;
    logic               w_stable;

    debug_edge_detect #(.W(3)) u_edge (
        .clk   (clk),
        .reset (reset),
        .btn   ({step_btn, run_btn, halt_btn}),
        .rise  (w_rise)
    );

    assign w_halt_e = w_rise[0];
    assign w_run_e  = w_rise[1];
    assign w_step_e = w_rise[2];

    // resume masks the breakpoint so a run from a breakpoint executes that instruction
    assign w_bp_hit = bp_en && (core_pc == bp_addr) && !r_resume;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= HALT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            HALT: begin
                if (w_halt_e)      w_next = HALT;
                else if (w_run_e)  w_next = RUN;
                else if (w_step_e) w_next = STEP;
            end
            RUN:     if (w_bp_hit || w_halt_e) w_next = HALT;
            STEP:    w_next = HALT;
            default: w_next = HALT;
        endcase
    end

    always_comb begin
        core_enable = 1'b0;
        halted      = 1'b0;
        case (r_state)
            HALT:    halted      = 1'b1;
            RUN:     core_enable = !w_bp_hit;
            STEP:    core_enable = 1'b1;
            default: halted      = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_resume    <= 1'b0;
            r_cycle_cnt <= '0;
        end else begin
            if (r_state == HALT && w_next == RUN) begin
                r_resume <= 1'b1;
            end else if (r_state == RUN) begin
                r_resume <= 1'b0;
            end
            if (core_enable && r_cycle_cnt != c_cycle_max) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
        end
    end

    assign cycle_count = r_cycle_cnt;

    // Readout: address/select registered first, source word captured one cycle later
    assign w_stable  = (derreference == r_rd_addr) && (select == r_sel_q);
    assign w_sel_ext = 32'(r_sel_q);

    always_comb begin
        w_word_next = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (w_sel_ext == k) w_word_next = src_data[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_addr <= '0;
            r_sel_q   <= '0;
            r_word    <= '0;
            r_vld_sr  <= 2'b00;
        end else begin
            r_rd_addr <= derreference;
            r_sel_q   <= select;
            r_word    <= w_word_next;
            r_vld_sr  <= {r_vld_sr[0] & w_stable, w_stable};
        end
    end

    assign rd_addr    = r_rd_addr;
    assign word       = r_word;
    assign word_valid = r_vld_sr[1];

endmodule
`default_nettype wire

// File: tb/tb_mips_debug_ctrl.sv
`default_nettype none
// Directed bench for mips_debug_ctrl: run/halt/step/breakpoint sequences and readout table.
module tb_mips_debug_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int N_SRC  = 4;
    localparam int SEL_W  = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    run_btn, halt_btn, step_btn, bp_en;
    logic [PC_W-1:0]         bp_addr;
    logic [PC_W-1:0]         pc;
    logic                    core_enable, halted;
    logic [31:0]             cycle_count;
    logic [ADDR_W-1:0]       derreference, rd_addr;
    logic [SEL_W-1:0]        select;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [DATA_W-1:0]       word;
    logic                    word_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_debug_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_W(PC_W), .N_SRC(N_SRC), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .reset(reset), .run_btn(run_btn), .halt_btn(halt_btn),
        .step_btn(step_btn), .bp_en(bp_en), .bp_addr(bp_addr), .core_pc(pc),
        .core_enable(core_enable), .halted(halted), .cycle_count(cycle_count),
        .derreference(derreference), .select(select), .rd_addr(rd_addr),
        .src_data(src_data), .word(word), .word_valid(word_valid)
    );

    // Simple core: PC advances by 4 on each enabled cycle
    always_ff @(posedge clk) begin
        if (!reset)          pc <= '0;
        else if (core_enable) pc <= pc + 32'd4;
    end

    // Synchronous-read sources; source 2 holds 0xDEADBEEF at address 5
    function automatic logic [31:0] srcf(input int k, input logic [ADDR_W-1:0] a);
        if (k == 2 && a == 10'h005) return 32'hDEAD_BEEF;
        return {8'(k), 8'hA5, 6'b0, a};
    endfunction

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_SRC; k++) src_data[k*DATA_W +: DATA_W] <= srcf(k, rd_addr);
    end

    typedef struct {
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp;
    } rd_vec_t;

    rd_vec_t tbl [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        tbl[0] = '{3'd2, 10'h005, 32'hDEAD_BEEF};
        tbl[1] = '{3'd1, 10'h005, 32'h01A5_0005};
        tbl[2] = '{3'd0, 10'h3FF, 32'h00A5_03FF};
        tbl[3] = '{3'd3, 10'h012, 32'h03A5_0012};
        tbl[4] = '{3'd5, 10'h012, 32'h0000_0000};
        tbl[5] = '{3'd7, 10'h000, 32'h0000_0000};
        tbl[6] = '{3'd2, 10'h006, 32'h02A5_0006};

        reset = 1'b0; run_btn = 1'b1; halt_btn = 1'b0; step_btn = 1'b0;
        bp_en = 1'b1; bp_addr = 32'h10; derreference = '0; select = '0;
        repeat (3) tick();
        chk("rst_halted", 64'(halted), 64'd1);
        chk("rst_enable", 64'(core_enable), 64'd0);
        chk("rst_count", 64'(cycle_count), 64'd0);
        chk("rst_word", 64'(word), 64'd0);
        chk("rst_valid", 64'(word_valid), 64'd0);

        // Held run button through reset must not start the core
        reset = 1'b1;
        repeat (2) tick();
        chk("held_no_run", 64'(halted), 64'd1);
        run_btn = 1'b0; tick();
        run_btn = 1'b1; tick();
        chk("run_halted", 64'(halted), 64'd0);
        chk("run_enable", 64'(core_enable), 64'd1);
        run_btn = 1'b0;

        // Breakpoint at 0x10
        repeat (4) tick();
        chk("bp_pc", 64'(pc), 64'h10);
        chk("bp_enable_low", 64'(core_enable), 64'd0);
        tick();
        chk("bp_halted", 64'(halted), 64'd1);
        chk("bp_count", 64'(cycle_count), 64'd4);

        // Resume from breakpoint executes the breakpointed instruction
        run_btn = 1'b1; tick();
        chk("resume_enable", 64'(core_enable), 64'd1);
        tick();
        run_btn = 1'b0;
        chk("resume_pc", 64'(pc), 64'h14);
        chk("resume_running", 64'(halted), 64'd0);
        halt_btn = 1'b1; tick();
        halt_btn = 1'b0;
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_count", 64'(cycle_count), 64'd6);

        // Single steps with breakpoint on the current PC
        bp_addr = pc;
        for (int i = 0; i < 3; i++) begin
            step_btn = 1'b1; tick();
            chk("step_pulse", 64'(core_enable), 64'd1);
            step_btn = 1'b0; tick();
            chk("step_end", 64'(core_enable), 64'd0);
            repeat (3) tick();
        end
        chk("step_count", 64'(cycle_count), 64'd9);
        chk("step_pc", 64'(pc), 64'h24);

        // Halt beats run in HALT
        run_btn = 1'b1; halt_btn = 1'b1; tick();
        chk("runhalt_1", 64'(halted), 64'd1);
        tick();
        chk("runhalt_2", 64'(halted), 64'd1);
        run_btn = 1'b0; halt_btn = 1'b0; bp_en = 1'b0; tick();

        // Run and step edges ignored while running
        run_btn = 1'b1; tick();
        run_btn = 1'b0; tick();
        run_btn = 1'b1; step_btn = 1'b1; tick();
        chk("ign_halted", 64'(halted), 64'd0);
        chk("ign_enable", 64'(core_enable), 64'd1);
        tick();
        chk("ign_count", 64'(cycle_count), 64'd12);
        run_btn = 1'b0; step_btn = 1'b0;
        halt_btn = 1'b1; tick();
        halt_btn = 1'b0;
        chk("ign_halt", 64'(halted), 64'd1);
        chk("ign_count2", 64'(cycle_count), 64'd13);

        // Readout table
        for (int i = 0; i < 7; i++) begin
            select = tbl[i].sel; derreference = tbl[i].addr;
            tick();
            chk("rd_drop", 64'(word_valid), 64'd0);
            tick();
            chk("rd_wait", 64'(word_valid), 64'd0);
            tick();
            chk("rd_valid", 64'(word_valid), 64'd1);
            chk("rd_word", 64'(word), 64'(tbl[i].exp));
        end

        // Saturation near the top of the counter
        @(negedge clk);
        force dut.r_cycle_cnt = 32'hFFFF_FFFE;
        #1 release dut.r_cycle_cnt;
        run_btn = 1'b1; tick();
        run_btn = 1'b0;
        chk("sat_start", 64'(cycle_count), 64'hFFFF_FFFE);
        tick();
        chk("sat_reach", 64'(cycle_count), 64'hFFFF_FFFF);
        repeat (3) tick();
        chk("sat_hold", 64'(cycle_count), 64'hFFFF_FFFF);

        // Reset mid-run
        reset = 1'b0; tick();
        chk("mid_rst_halted", 64'(halted), 64'd1);
        chk("mid_rst_count", 64'(cycle_count), 64'd0);
        chk("mid_rst_word", 64'(word), 64'd0);
        chk("mid_rst_valid", 64'(word_valid), 64'd0);
        chk("mid_rst_enable", 64'(core_enable), 64'd0);
        reset = 1'b1;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
